// File: rtl/eka_seq_ctrl.sv
// eka_seq_ctrl: multi-cycle sequencer for the Eka core.
// Owns PC, instruction register and retired-instruction counter, and walks each
// instruction through FETCH -> DECODE -> EXECUTE -> [MEM] -> [WB] using the
// flags from the external combinational decoder. Fetch and data accesses use a
// simple req/ack handshake guarded by a shared wait-cycle timeout. Every output
// is a flop, so there is no combinational path from an ack to a request.
module eka_seq_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  // instruction memory
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  // decoder
  output logic [31:0] ir,
  input  logic        dec_valid,
  input  logic        dec_branch,
  input  logic        dec_mem_rd,
  input  logic        dec_mem_wr,
  input  logic        dec_reg_wr,
  input  logic [31:0] imm,
  input  logic        br_taken,
  // data memory
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  // register file / status
  output logic        rf_wr_en,
  output logic [31:0] pc,
  output logic [31:0] instret,
  output logic        halted,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_IMEM_TO = 2'd2,
    ERR_DMEM_TO = 2'd3
  } err_e;

  // Wait count at which the current request cycle is the last one allowed.
  localparam logic [31:0] TO_LAST = MEM_TIMEOUT - 32'd1;

  state_e      state_q;
  logic        rel_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] instret_q;
  logic [31:0] wait_cnt_q;
  logic        imem_req_q;
  logic        dmem_req_q;
  logic        dmem_we_q;
  logic        rf_wr_en_q;
  logic        halted_q;
  err_e        err_q;

  logic [31:0] pc_d;
  logic [31:0] instret_d;
  logic        timeout_hit;

  // Retire targets: branch target or fall-through, both 32-bit modulo.
  assign pc_d        = (dec_branch & br_taken) ? pc_q + imm : pc_q + 32'd4;
  assign instret_d   = instret_q + 32'd1;
  // The current request cycle is the last permitted one and no ack came.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_q == TO_LAST);

  // Synchronous release: the FSM leaves IDLE only once reset release has been
  // seen by a clock edge, so IDLE lasts one full cycle after the release edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rel_q <= 1'b0;
    end else begin
      rel_q <= 1'b1;
    end
  end

  // Main sequencer: state, architectural registers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= 32'h0;
      instret_q  <= 32'h0;
      wait_cnt_q <= 32'h0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_wr_en_q <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= ERR_NONE;
    end else begin
      // NOTE: state updates use <= so every branch sees pre-edge values; the
      // write strobe defaults low here so it can only be a one-cycle pulse.
      rf_wr_en_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (rel_q) begin
            state_q    <= S_FETCH;
            imem_req_q <= 1'b1;
            wait_cnt_q <= 32'h0;
          end
        end

        S_FETCH: begin
          if (imem_ack) begin
            ir_q       <= imem_rdata;
            imem_req_q <= 1'b0;
            state_q    <= S_DECODE;
          end else if (timeout_hit) begin
            imem_req_q <= 1'b0;
            halted_q   <= 1'b1;
            err_q      <= ERR_IMEM_TO;
            state_q    <= S_HALT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
          end
        end

        S_DECODE: begin
          if (!dec_valid) begin
            halted_q <= 1'b1;
            err_q    <= ERR_ILLEGAL;
            state_q  <= S_HALT;
          end else begin
            state_q  <= S_EXECUTE;
          end
        end

        S_EXECUTE: begin
          if (dec_mem_rd | dec_mem_wr) begin
            dmem_req_q <= 1'b1;
            dmem_we_q  <= dec_mem_wr;
            wait_cnt_q <= 32'h0;
            state_q    <= S_MEM;
          end else if (dec_reg_wr) begin
            rf_wr_en_q <= 1'b1;
            state_q    <= S_WB;
          end else begin
            pc_q       <= pc_d;
            instret_q  <= instret_d;
            imem_req_q <= 1'b1;
            wait_cnt_q <= 32'h0;
            state_q    <= S_FETCH;
          end
        end

        S_MEM: begin
          if (dmem_ack) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            if (dmem_we_q) begin
              // Store completes here and retires without a writeback.
              pc_q       <= pc_d;
              instret_q  <= instret_d;
              imem_req_q <= 1'b1;
              wait_cnt_q <= 32'h0;
              state_q    <= S_FETCH;
            end else begin
              rf_wr_en_q <= 1'b1;
              state_q    <= S_WB;
            end
          end else if (timeout_hit) begin
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            halted_q   <= 1'b1;
            err_q      <= ERR_DMEM_TO;
            state_q    <= S_HALT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
          end
        end

        S_WB: begin
          pc_q       <= pc_d;
          instret_q  <= instret_d;
          imem_req_q <= 1'b1;
          wait_cnt_q <= 32'h0;
          state_q    <= S_FETCH;
        end

        S_HALT: begin
          // Absorbing; only reset leaves this state.
          state_q <= S_HALT;
        end

        default: begin
          state_q <= S_HALT;
        end
      endcase
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign dmem_req  = dmem_req_q;
  assign dmem_we   = dmem_we_q;
  assign rf_wr_en  = rf_wr_en_q;
  assign pc        = pc_q;
  assign instret   = instret_q;
  assign halted    = halted_q;
  assign err_code  = err_q;

endmodule
